// File: rtl/dispatch_queue_unit.sv
// Dispatch stage: decoded-instruction FIFO feeding ROB/RS/LSB,
// with operand resolution from regfile, ROB, CDB and a rename bypass.
module dispatch_queue_unit #(
  parameter int XLEN       = 32,
  parameter int OP_W       = 6,
  parameter int ROB_ID_W   = 4,
  parameter int CDB_N      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     rollback_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_rollback_pc,
  input  logic                     in_pred_jump,
  input  logic [4:0]               in_flags,
  output logic [4:0]               rs1_out,
  output logic [4:0]               rs2_out,
  input  logic [XLEN-1:0]          reg_v1,
  input  logic [XLEN-1:0]          reg_v2,
  input  logic [ROB_ID_W-1:0]      reg_q1,
  input  logic [ROB_ID_W-1:0]      reg_q2,
  output logic [ROB_ID_W-1:0]      rob_q1_out,
  output logic [ROB_ID_W-1:0]      rob_q2_out,
  input  logic                     rob_rdy1,
  input  logic                     rob_rdy2,
  input  logic [XLEN-1:0]          rob_data1,
  input  logic [XLEN-1:0]          rob_data2,
  input  logic                     rob_full_in,
  input  logic                     rs_full_in,
  input  logic                     lsb_full_in,
  input  logic [ROB_ID_W-1:0]      rob_id_in,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id,
  input  logic [CDB_N*XLEN-1:0]    cdb_data,
  output logic                     rob_en,
  output logic                     reg_en,
  output logic                     rs_en,
  output logic                     lsb_en,
  output logic [OP_W-1:0]          out_op,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_v1,
  output logic [XLEN-1:0]          out_v2,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_rollback_pc,
  output logic [ROB_ID_W-1:0]      out_q1,
  output logic [ROB_ID_W-1:0]      out_q2,
  output logic [ROB_ID_W-1:0]      out_rob_id,
  output logic [4:0]               out_flags,
  output logic                     out_pred_jump
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rpc;
    logic            pj;
    logic [4:0]      flags;
  } ent_t;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [4:0]          rd;
    logic [XLEN-1:0]     v1;
    logic [XLEN-1:0]     v2;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rpc;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [ROB_ID_W-1:0] rob_id;
    logic [4:0]          flags;
    logic                pj;
  } pay_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] q;
    logic [XLEN-1:0]     v;
  } opnd_t;

  ent_t          mem_q [FIFO_DEPTH];
  ent_t          in_ent, head;
  logic [PW-1:0] hd_q, hd_d, tl_q, tl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rob_en_q, rob_en_d, reg_en_q, reg_en_d;
  logic          rs_en_q, rs_en_d, lsb_en_q, lsb_en_d;
  pay_t          pay_q, pay_d;
  logic          lvld_q, lvld_d;
  logic [4:0]    lrd_q, lrd_d;
  logic [ROB_ID_W-1:0] lid_q, lid_d;
  logic          push, pop, go, drop, is_lsb, unit_ok, live;
  opnd_t         op1, op2;

  function automatic opnd_t resolve(
    input logic [4:0]          rs,
    input logic [XLEN-1:0]     rv,
    input logic [ROB_ID_W-1:0] rq,
    input logic                rr,
    input logic [XLEN-1:0]     rdat
  );
    opnd_t r;
    logic  hit;
    logic [XLEN-1:0] cv;
    hit = 1'b0;
    cv  = '0;
    for (int i = 0; i < CDB_N; i++) begin
      if (!hit && cdb_valid[i] &&
          cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == rq) begin
        hit = 1'b1;
        cv  = cdb_data[i*XLEN +: XLEN];
      end
    end
    if (rs == 5'd0)                   r = '{q: '0, v: '0};
    else if (lvld_q && lrd_q == rs)   r = '{q: lid_q, v: '0};
    else if (rq == '0)                r = '{q: '0, v: rv};
    else if (hit)                     r = '{q: '0, v: cv};
    else if (rr)                      r = '{q: '0, v: rdat};
    else                              r = '{q: rq, v: rv};
    return r;
  endfunction

  always_comb begin
    in_ent = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
               imm: in_imm, pc: in_pc, rpc: in_rollback_pc,
               pj: in_pred_jump, flags: in_flags};
    head    = mem_q[hd_q];
    is_lsb  = head.flags[4];
    unit_ok = is_lsb ? !lsb_full_in : !rs_full_in;
    live    = rdy_in && !rollback_in && (cnt_q != '0);
    go      = live && !rob_full_in && unit_ok && (head.op != '0);
    drop    = live && (head.op == '0);
    pop     = go || drop;
    push    = in_valid && in_ready && rdy_in;
    op1 = resolve(head.rs1, reg_v1, reg_q1, rob_rdy1, rob_data1);
    op2 = resolve(head.rs2, reg_v2, reg_q2, rob_rdy2, rob_data2);
  end

  always_comb begin
    hd_d     = hd_q;
    tl_d     = tl_q;
    cnt_d    = cnt_q;
    pay_d    = pay_q;
    lvld_d   = lvld_q;
    lrd_d    = lrd_q;
    lid_d    = lid_q;
    rob_en_d = 1'b0;
    reg_en_d = 1'b0;
    rs_en_d  = 1'b0;
    lsb_en_d = 1'b0;
    if (rdy_in) begin
      if (rollback_in) begin
        hd_d   = '0;
        tl_d   = '0;
        cnt_d  = '0;
        lvld_d = 1'b0;
      end else begin
        if (push) tl_d = tl_q + 1'b1;
        if (pop)  hd_d = hd_q + 1'b1;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        lvld_d = go && (head.rd != 5'd0);
        if (go) begin
          rob_en_d = 1'b1;
          reg_en_d = head.rd != 5'd0;
          rs_en_d  = !is_lsb;
          lsb_en_d = is_lsb;
          lrd_d    = head.rd;
          lid_d    = rob_id_in;
          pay_d = '{op: head.op, rd: head.rd, v1: op1.v, v2: op2.v,
                    imm: head.imm, pc: head.pc, rpc: head.rpc,
                    q1: op1.q, q2: op2.q, rob_id: rob_id_in,
                    flags: head.flags, pj: head.pj};
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hd_q     <= '0;
      tl_q     <= '0;
      cnt_q    <= '0;
      pay_q    <= '0;
      lvld_q   <= 1'b0;
      lrd_q    <= '0;
      lid_q    <= '0;
      rob_en_q <= 1'b0;
      reg_en_q <= 1'b0;
      rs_en_q  <= 1'b0;
      lsb_en_q <= 1'b0;
    end else begin
      hd_q     <= hd_d;
      tl_q     <= tl_d;
      cnt_q    <= cnt_d;
      pay_q    <= pay_d;
      lvld_q   <= lvld_d;
      lrd_q    <= lrd_d;
      lid_q    <= lid_d;
      rob_en_q <= rob_en_d;
      reg_en_q <= reg_en_d;
      rs_en_q  <= rs_en_d;
      lsb_en_q <= lsb_en_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[tl_q] <= in_ent;
  end

  assign in_ready        = (cnt_q < CW'(FIFO_DEPTH)) && !rollback_in;
  assign rs1_out         = head.rs1;
  assign rs2_out         = head.rs2;
  assign rob_q1_out      = reg_q1;
  assign rob_q2_out      = reg_q2;
  assign rob_en          = rob_en_q;
  assign reg_en          = reg_en_q;
  assign rs_en           = rs_en_q;
  assign lsb_en          = lsb_en_q;
  assign out_op          = pay_q.op;
  assign out_rd          = pay_q.rd;
  assign out_v1          = pay_q.v1;
  assign out_v2          = pay_q.v2;
  assign out_imm         = pay_q.imm;
  assign out_pc          = pay_q.pc;
  assign out_rollback_pc = pay_q.rpc;
  assign out_q1          = pay_q.q1;
  assign out_q2          = pay_q.q2;
  assign out_rob_id      = pay_q.rob_id;
  assign out_flags       = pay_q.flags;
  assign out_pred_jump   = pay_q.pj;
endmodule

// File: tb/tb_dispatch_queue_unit.sv
// Directed bench for dispatch_queue_unit: operand table plus
// multi-cycle sequences (bypass, backpressure, rollback, reset).
module tb_dispatch_queue_unit;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, rollback_in, in_valid, in_ready;
  logic [5:0]  in_op, out_op;
  logic [4:0]  in_rd, in_rs1, in_rs2, in_flags, rs1_out, rs2_out;
  logic [31:0] in_imm, in_pc, in_rollback_pc;
  logic        in_pred_jump;
  logic [31:0] reg_v1, reg_v2, rob_data1, rob_data2;
  logic [3:0]  reg_q1, reg_q2, rob_q1_out, rob_q2_out, rob_id_in;
  logic        rob_rdy1, rob_rdy2, rob_full_in, rs_full_in, lsb_full_in;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_data;
  logic        rob_en, reg_en, rs_en, lsb_en, out_pred_jump;
  logic [4:0]  out_rd, out_flags;
  logic [31:0] out_v1, out_v2, out_imm, out_pc, out_rollback_pc;
  logic [3:0]  out_q1, out_q2, out_rob_id;

  int errs = 0;
  int checks = 0;

  dispatch_queue_unit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .rollback_in(rollback_in), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pc(in_pc), .in_rollback_pc(in_rollback_pc),
    .in_pred_jump(in_pred_jump), .in_flags(in_flags),
    .rs1_out(rs1_out), .rs2_out(rs2_out),
    .reg_v1(reg_v1), .reg_v2(reg_v2),
    .reg_q1(reg_q1), .reg_q2(reg_q2),
    .rob_q1_out(rob_q1_out), .rob_q2_out(rob_q2_out),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
    .rob_data1(rob_data1), .rob_data2(rob_data2),
    .rob_full_in(rob_full_in), .rs_full_in(rs_full_in),
    .lsb_full_in(lsb_full_in), .rob_id_in(rob_id_in),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_data(cdb_data), .rob_en(rob_en), .reg_en(reg_en),
    .rs_en(rs_en), .lsb_en(lsb_en), .out_op(out_op),
    .out_rd(out_rd), .out_v1(out_v1), .out_v2(out_v2),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_rollback_pc(out_rollback_pc), .out_q1(out_q1),
    .out_q2(out_q2), .out_rob_id(out_rob_id),
    .out_flags(out_flags), .out_pred_jump(out_pred_jump)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  rd, rs1, rs2, flags;
    logic [3:0]  rq1;
    logic [31:0] rv1;
    logic [3:0]  rq2;
    logic [31:0] rv2;
    logic        rr1;
    logic [31:0] rd1;
    logic        rr2;
    logic [31:0] rd2;
    logic [1:0]  cv;
    logic [7:0]  cid;
    logic [63:0] cdat;
    logic [3:0]  rid;
    logic        e_rs, e_lsb, e_reg;
    logic [3:0]  e_q1;
    logic [31:0] e_v1;
    logic [3:0]  e_q2;
    logic [31:0] e_v2;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_flags = 0; in_imm = 0; in_pc = 0; in_rollback_pc = 0;
    in_pred_jump = 0;
    reg_v1 = 0; reg_v2 = 0; reg_q1 = 0; reg_q2 = 0;
    rob_rdy1 = 0; rob_rdy2 = 0; rob_data1 = 0; rob_data2 = 0;
    cdb_valid = 0; cdb_rob_id = 0; cdb_data = 0;
  endtask

  task automatic put(input logic [5:0] op, input logic [4:0] rd,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] fl);
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = r1;
    in_rs2 = r2; in_flags = fl;
    in_imm = 32'h100 + 32'(rd);
    in_pc = 32'h4000 + 32'(rd);
    in_rollback_pc = 32'h8000 + 32'(rd);
    in_pred_jump = rd[0];
    tick();
    in_valid = 0;
  endtask

  task automatic strobes(input string nm, input logic [3:0] e);
    chk(nm, {60'd0, rob_en, reg_en, rs_en, lsb_en}, {60'd0, e});
  endtask

  initial begin
    vt[0] = '{5'd0, 5'd0, 5'd1, 5'b00000, 4'd3, 32'h99, 4'd0, 32'h5,
              1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 8'h00, 64'h0, 4'd1,
              1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 32'h5};
    vt[1] = '{5'd3, 5'd1, 5'd2, 5'b00000, 4'd7, 32'hAA, 4'd0, 32'h33,
              1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 8'h77,
              64'h00000022_00000011, 4'd2,
              1'b1, 1'b0, 1'b1, 4'd0, 32'h11, 4'd0, 32'h33};
    vt[2] = '{5'd4, 5'd3, 5'd4, 5'b00000, 4'd5, 32'hA1, 4'd6, 32'hA2,
              1'b0, 32'h0, 1'b1, 32'h66, 2'b10, 8'h55,
              64'h00000055_00000044, 4'd5,
              1'b1, 1'b0, 1'b1, 4'd0, 32'h55, 4'd0, 32'h66};
    vt[3] = '{5'd5, 5'd6, 5'd7, 5'b00000, 4'd4, 32'hB1, 4'd9, 32'h1234,
              1'b1, 32'h88, 1'b0, 32'h99, 2'b01, 8'h04,
              64'h00000000_00000077, 4'd6,
              1'b1, 1'b0, 1'b1, 4'd0, 32'h77, 4'd9, 32'h1234};
    vt[4] = '{5'd7, 5'd8, 5'd0, 5'b11000, 4'd0, 32'h1000, 4'd2, 32'hC2,
              1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 8'h00, 64'h0, 4'd7,
              1'b0, 1'b1, 1'b1, 4'd0, 32'h1000, 4'd0, 32'h0};
    vt[5] = '{5'd9, 5'd10, 5'd11, 5'b00000, 4'd2, 32'hD1, 4'd15, 32'hD2,
              1'b0, 32'hEE, 1'b1, 32'hF2, 2'b11, 8'h33,
              64'h00000001_00000002, 4'd15,
              1'b1, 1'b0, 1'b1, 4'd2, 32'hD1, 4'd0, 32'hF2};

    quiet();
    rdy_in = 1; rollback_in = 0; rob_id_in = 0;
    rob_full_in = 0; rs_full_in = 0; lsb_full_in = 0;
    rst_n_in = 0;
    #12;
    strobes("reset_strobes", 4'b0000);
    chk("reset_out_v1", 64'(out_v1), 64'h0);
    chk("reset_rob_id", 64'(out_rob_id), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk_in);
    rst_n_in = 1;
    tick();

    foreach (vt[i]) begin
      put(6'd1, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].flags);
      chk($sformatf("v%0d_rs1_out", i), 64'(rs1_out), 64'(vt[i].rs1));
      reg_q1 = vt[i].rq1; reg_v1 = vt[i].rv1;
      reg_q2 = vt[i].rq2; reg_v2 = vt[i].rv2;
      rob_rdy1 = vt[i].rr1; rob_data1 = vt[i].rd1;
      rob_rdy2 = vt[i].rr2; rob_data2 = vt[i].rd2;
      cdb_valid = vt[i].cv; cdb_rob_id = vt[i].cid;
      cdb_data = vt[i].cdat; rob_id_in = vt[i].rid;
      tick();
      strobes($sformatf("v%0d_strobes", i),
              {1'b1, vt[i].e_reg, vt[i].e_rs, vt[i].e_lsb});
      chk($sformatf("v%0d_q1", i), 64'(out_q1), 64'(vt[i].e_q1));
      chk($sformatf("v%0d_v1", i), 64'(out_v1), 64'(vt[i].e_v1));
      chk($sformatf("v%0d_q2", i), 64'(out_q2), 64'(vt[i].e_q2));
      chk($sformatf("v%0d_v2", i), 64'(out_v2), 64'(vt[i].e_v2));
      chk($sformatf("v%0d_rob_id", i), 64'(out_rob_id), 64'(vt[i].rid));
      chk($sformatf("v%0d_rd_imm", i), {27'd0, out_rd, out_imm},
          {27'd0, vt[i].rd, 32'h100 + 32'(vt[i].rd)});
      chk($sformatf("v%0d_flags", i), 64'(out_flags), 64'(vt[i].flags));
      quiet();
    end
    tick();
    strobes("idle_after_table", 4'b0000);

    // Back-to-back rename: ADDI x5 then ADD x6,x5,x5.
    rob_full_in = 1;
    put(6'd2, 5'd5, 5'd0, 5'd0, 5'b00000);
    put(6'd1, 5'd6, 5'd5, 5'd5, 5'b00000);
    rob_full_in = 0; rob_id_in = 3; reg_v1 = 32'h50; reg_v2 = 32'h50;
    tick();
    strobes("byp_first", 4'b1110);
    chk("byp_first_rd", 64'(out_rd), 64'd5);
    rob_id_in = 4;
    tick();
    strobes("byp_second", 4'b1110);
    chk("byp_q1q2", {out_q1, out_q2}, 8'h33);
    chk("byp_v1", 64'(out_v1), 64'h0);
    chk("byp_rob_id", 64'(out_rob_id), 64'd4);
    tick();
    strobes("byp_done", 4'b0000);

    // Bypass record expires after a stall cycle.
    rob_full_in = 1;
    put(6'd2, 5'd5, 5'd0, 5'd0, 5'b00000);
    put(6'd1, 5'd6, 5'd5, 5'd0, 5'b00000);
    rob_full_in = 0; rob_id_in = 3;
    tick();
    strobes("exp_first", 4'b1110);
    rob_full_in = 1;
    tick();
    strobes("exp_stall", 4'b0000);
    rob_full_in = 0; rob_id_in = 8; reg_v1 = 32'hAB; reg_q1 = 0;
    tick();
    strobes("exp_second", 4'b1110);
    chk("exp_q1", 64'(out_q1), 64'h0);
    chk("exp_v1", 64'(out_v1), 64'hAB);
    quiet();

    // LSB backpressure; following ADD must not overtake.
    lsb_full_in = 1;
    put(6'd3, 5'd8, 5'd2, 5'd0, 5'b11000);
    strobes("bp_c1", 4'b0000);
    put(6'd1, 5'd9, 5'd1, 5'd2, 5'b00000);
    strobes("bp_c2", 4'b0000);
    tick();
    strobes("bp_c3", 4'b0000);
    lsb_full_in = 0; rob_id_in = 10;
    tick();
    strobes("bp_lw", 4'b1101);
    chk("bp_lw_rd", 64'(out_rd), 64'd8);
    rob_id_in = 11;
    tick();
    strobes("bp_add", 4'b1110);
    chk("bp_add_rd", 64'(out_rd), 64'd9);

    // Invalid op at head is discarded silently.
    put(6'd0, 5'd12, 5'd1, 5'd1, 5'b00000);
    put(6'd1, 5'd10, 5'd1, 5'd1, 5'b00000);
    strobes("drop_none", 4'b0000);
    tick();
    strobes("drop_next", 4'b1110);
    chk("drop_rd", 64'(out_rd), 64'd10);

    // rdy_in low freezes dispatch.
    put(6'd1, 5'd11, 5'd0, 5'd0, 5'b00000);
    rdy_in = 0;
    tick();
    strobes("frz_hold", 4'b0000);
    rdy_in = 1;
    tick();
    strobes("frz_go", 4'b1110);
    chk("frz_rd", 64'(out_rd), 64'd11);

    // Full FIFO, then rollback with a simultaneous push.
    rob_full_in = 1;
    for (int k = 0; k < 4; k++) put(6'd1, 5'(13 + k), 5'd0, 5'd0, 5'd0);
    chk("full_ready", 64'(in_ready), 64'h0);
    rob_full_in = 0; rollback_in = 1;
    in_valid = 1; in_op = 6'd1; in_rd = 5'd20;
    #1;
    chk("rb_ready_low", 64'(in_ready), 64'h0);
    tick();
    rollback_in = 0; in_valid = 0;
    #1;
    strobes("rb_strobes", 4'b0000);
    chk("rb_ready", 64'(in_ready), 64'h1);
    tick();
    strobes("rb_empty", 4'b0000);

    // Asynchronous reset mid-stream.
    rob_full_in = 1;
    for (int k = 0; k < 3; k++) put(6'd1, 5'(21 + k), 5'd0, 5'd0, 5'd0);
    rob_full_in = 0;
    tick();
    strobes("rst_pre", 4'b1110);
    rst_n_in = 0;
    #1;
    strobes("rst_now", 4'b0000);
    chk("rst_rd", 64'(out_rd), 64'h0);
    @(negedge clk_in);
    rst_n_in = 1;
    #1;
    chk("rst_ready", 64'(in_ready), 64'h1);
    tick();
    strobes("rst_empty", 4'b0000);
    tick();
    strobes("rst_empty2", 4'b0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dispatch_queue_unit.md
Name: dispatch_queue_unit

Overview:
Parametrised next-generation dispatch stage, placed between the fetcher/decoder and the ROB, reservation station (RS) and load/store buffer (LSB). Features:
- Valid/ready input handshake into a decoded-instruction FIFO.
- Dispatches the FIFO head only when the ROB and the target unit both have space.
- Resolves operands from the register file, the ROB and N CDB channels.
- Bypasses back-to-back rename hazards internally.
- Flushes completely on rollback.

Parameters:
- XLEN, 32, data/address width.
- OP_W, 6, op-enum width.
- ROB_ID_W, 4, ROB tag width. Tag 0 means "no dependency"; valid tags are 1..2^ROB_ID_W-1.
- CDB_N, 2, number of CDB broadcast channels. Channel 0 has the highest priority.
- FIFO_DEPTH, 4, decoded-instruction FIFO entries. Must be a power of two, ≥2.

Ports:
- clk_in  in  1  clock; all state changes on the rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; when low, all state is frozen.
- rollback_in  in  1  flush request from the ROB.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  FIFO can accept; asserted when count<FIFO_DEPTH and rollback_in is low.
- in_op  in  OP_W  op enum.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm, in_pc, in_rollback_pc  in  XLEN each  immediate, PC, rollback PC.
- in_pred_jump  in  1  predicted-taken flag.
- in_flags  in  5  {is_lsb, is_load, is_store, is_jump, is_jalr}.
- rs1_out, rs2_out  out  5 each  register-file query, driven combinationally from the head entry.
- reg_v1, reg_v2  in  XLEN each  register-file values.
- reg_q1, reg_q2  in  ROB_ID_W each  register-file rename tags.
- rob_q1_out, rob_q2_out  out  ROB_ID_W each  equal reg_q1/reg_q2.
- rob_rdy1, rob_rdy2  in  1 each  ROB entry for the tag has a result.
- rob_data1, rob_data2  in  XLEN each  that result.
- rob_full_in, rs_full_in, lsb_full_in  in  1 each  backpressure.
- rob_id_in  in  ROB_ID_W  tag the ROB will allocate next.
- cdb_valid  in  CDB_N  per-channel broadcast valid.
- cdb_rob_id  in  CDB_N*ROB_ID_W  packed broadcast tags.
- cdb_data  in  CDB_N*XLEN  packed broadcast results.
- rob_en, reg_en, rs_en, lsb_en  out  1 each  one-cycle registered dispatch strobes.
- out_op  out  OP_W  dispatched op.
- out_rd  out  5  dispatched destination register.
- out_v1, out_v2, out_imm, out_pc, out_rollback_pc  out  XLEN each  dispatched payload.
- out_q1, out_q2, out_rob_id  out  ROB_ID_W each  dispatched tags.
- out_flags  out  5  dispatched flags.
- out_pred_jump  out  1  dispatched prediction flag.

Behaviour:
- Reset:
  - While rst_n_in is low, the FIFO is empty (head=tail=count=0).
  - All strobes are 0; all payload outputs, and the last-rename record, are 0.
- FIFO push when in_valid&&in_ready. The FIFO is circular with head/tail wrap at FIFO_DEPTH. Push and pop in the same cycle leave count unchanged.
- Dispatch condition ("go"), all of the following:
  - rdy_in=1, rollback_in=0, count>0, rob_full_in=0;
  - and (flags.is_lsb ? !lsb_full_in : !rs_full_in);
  - and head op != 0.
- Head entry with op==0 (invalid) is popped and discarded: no strobes and no rename.
- On go, at the next edge:
  - Pop the head.
  - Assert rob_en=1.
  - Assert rs_en=!is_lsb and lsb_en=is_lsb.
  - Assert reg_en=(rd!=0).
  - Latch the payload, with out_rob_id=rob_id_in.
- Strobes are exactly one cycle per dispatch. Back-to-back dispatch every cycle is supported (throughput 1/cycle).
- Operand resolution for source i, per source, first match wins:
  1. rs_i==0 → Q=0, V=0.
  2. Bypass: the previous cycle dispatched with reg_en and last_rd==rs_i → Q=last_rob_id, V=0.
  3. reg_q_i==0 → Q=0, V=reg_v_i.
  4. The lowest-index CDB channel with valid and a matching tag → Q=0, V=that channel's data.
  5. rob_rdy_i → Q=0, V=rob_data_i.
  6. Otherwise → Q=reg_q_i, V=reg_v_i.
- Consumers snoop the CDB themselves from the strobe cycle onward. The dispatcher forwards only CDB values visible in the lookup cycle.
- Stall: when go=0 with count>0, the head is held and the strobes are 0 next cycle. The bypass record stays valid only for the single cycle immediately after its dispatch.
- Rollback: rollback_in=1 at an edge empties the FIFO, zeroes the strobes, clears the bypass record and discards any same-cycle push. This takes priority over go and push.
- rdy_in=0: no push, no pop, strobes forced 0, all other state held.

Test Plan:
- Reset mid-stream: 3 entries queued, rst_n_in low for 1 cycle → strobes 0 immediately, count 0, in_ready=1 after release.
- Dependency bypass: ADDI x5 (rob_id_in=3) then ADD x6,x5,x5 on consecutive cycles, reg_q=0 → second dispatch has out_q1=out_q2=3.
- CDB forwarding: reg_q1=7, cdb_valid=2'b11, both channels tag 7, data 0x11 on ch0 and 0x22 on ch1 → out_q1=0, out_v1=0x11.
- Backpressure: LW at head with lsb_full_in=1 for 3 cycles → lsb_en=0 throughout, then 1 exactly one cycle after lsb_full_in drops. A following ADD does not overtake.
- Full FIFO plus rollback: with FIFO_DEPTH=4 and 4 entries, in_ready=0. Assert rollback_in with in_valid=1 → count 0, no strobes next cycle, pushed entry dropped.
- x0 handling: ADD x0,x0,x1 with reg_q2=0, reg_v2=0x5 → rs_en=1, reg_en=0, out_v1=0, out_q1=0, out_v2=0x5.
